// File: rtl/frame_scheduler.sv
// Frame-level sequencer between the framegrabber, the sequentializer and the
// downstream NN. It starts each frame, counts pixels, watches for stalls and
// counts completed and dropped frames.
module frame_scheduler #(
  parameter int IN_ROWS        = 20,
  parameter int IN_COLS        = 20,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        sof,
  output logic        seq_ap_start,
  input  logic        seq_ap_ready,
  input  logic        seq_ap_idle,
  input  logic        nn_ap_ready,
  input  logic        pix_hs,
  input  logic        clear_err,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt,
  output logic        timeout_err,
  // Counter preload, used to bring the counters to their wrap and
  // saturation points without running 65k frames.
  input  logic        cnt_load_i,
  input  logic [15:0] cnt_load_frame_i,
  input  logic [15:0] cnt_load_drop_i,
  output logic [2:0]  dbg_state_o
);

  localparam int NPIX  = IN_ROWS * IN_COLS;
  localparam int PIX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NPIX - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [15:0]       frame_q, frame_d;
  logic [15:0]       drop_q, drop_d;

  // Handshakes: seq_ap_start is a request held high for the whole of ARM;
  // the cycle in which seq_ap_ready and nn_ap_ready are both high is the
  // acceptance, and ARM leaves at that edge. pix_hs is already a completed
  // transfer (tvalid & tready) and is only counted while in RUN.
  always_comb begin
    state_d      = state_q;
    pix_d        = pix_q;
    wd_d         = wd_q;
    frame_d      = frame_q;
    drop_d       = drop_q;
    seq_ap_start = 1'b0;
    frame_done   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (sof && enable) state_d = ST_ARM;
      end
      ST_ARM: begin
        seq_ap_start = 1'b1;
        if (seq_ap_ready && nn_ap_ready) begin
          state_d = ST_RUN;
          pix_d   = '0;
          wd_d    = '0;
        end
      end
      ST_RUN: begin
        // A handshake in the last watchdog cycle wins over the timeout.
        if (pix_hs) begin
          wd_d = '0;
          if (pix_q == PIX_LAST) begin
            pix_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            pix_d = pix_q + PIX_W'(1);
          end
        end else if (wd_q == WD_LAST) begin
          state_d = ST_ERR;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      ST_DRAIN: begin
        if (seq_ap_idle) begin
          frame_done = 1'b1;
          frame_d    = frame_q + 16'd1;
          state_d    = ST_IDLE;
        end
      end
      ST_ERR: begin
        if (clear_err) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (sof && !(state_q == ST_IDLE && enable) && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end

    if (cnt_load_i) begin
      frame_d = cnt_load_frame_i;
      drop_d  = cnt_load_drop_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pix_q   <= '0;
      wd_q    <= '0;
      frame_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      wd_q    <= wd_d;
      frame_q <= frame_d;
      drop_q  <= drop_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign timeout_err = (state_q == ST_ERR);
  assign frame_cnt   = frame_q;
  assign drop_cnt    = drop_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler (4x8 frame, 16-cycle watchdog): stimulus
// pushes the expected frame count per completed frame, a monitor checks it.
module tb_frame_scheduler;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARM   = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic        clk = 1'b0;
  logic        reset, enable, sof;
  logic        seq_ap_start, seq_ap_ready, seq_ap_idle, nn_ap_ready;
  logic        pix_hs, clear_err, busy, frame_done, timeout_err;
  logic [15:0] frame_cnt, drop_cnt;
  logic        cnt_load;
  logic [15:0] load_frame, load_drop;
  logic [2:0]  dbg_state;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_frames = '0;

  frame_scheduler #(.IN_ROWS(4), .IN_COLS(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sof(sof),
    .seq_ap_start(seq_ap_start), .seq_ap_ready(seq_ap_ready),
    .seq_ap_idle(seq_ap_idle), .nn_ap_ready(nn_ap_ready),
    .pix_hs(pix_hs), .clear_err(clear_err), .busy(busy),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt),
    .timeout_err(timeout_err), .cnt_load_i(cnt_load),
    .cnt_load_frame_i(load_frame), .cnt_load_drop_i(load_drop),
    .dbg_state_o(dbg_state)
  );

  // Clock and global time limit
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL time_limit: got no end of test, required finish");
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; sof = 1'b0; pix_hs = 1'b0; clear_err = 1'b0;
    seq_ap_idle = 1'b0; cnt_load = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("sb_empty_at_reset", exp_q.size(), 0);
    exp_frames = '0;
  endtask

  task automatic sof_pulse();
    sof = 1'b1; tick(); sof = 1'b0;
  endtask

  task automatic pixels(input int n);
    pix_hs = 1'b1;
    repeat (n) tick();
    pix_hs = 1'b0;
  endtask

  task automatic finish_frame();
    exp_frames = exp_frames + 16'd1;
    exp_q.push_back(exp_frames);
    seq_ap_idle = 1'b1; tick(); seq_ap_idle = 1'b0;
  endtask

  // Monitor: a frame_done seen on one falling edge is checked against the
  // scoreboard on the next falling edge, once frame_cnt has updated.
  initial begin : monitor
    bit          pend = 1'b0;
    logic [15:0] exp_v;
    forever begin
      @(negedge clk);
      if (pend) begin
        pend = 1'b0;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL frame_done_unexpected: got pulse (frame_cnt=%0h) required none", frame_cnt);
        end else begin
          exp_v = exp_q.pop_front();
          check("frame_cnt_after_done", frame_cnt, exp_v);
        end
      end
      if (frame_done === 1'b1) pend = 1'b1;
    end
  end

  initial begin : stimulus
    int start_cycles;
    reset = 1'b1; enable = 1'b0; sof = 1'b0; seq_ap_ready = 1'b0;
    seq_ap_idle = 1'b0; nn_ap_ready = 1'b0; pix_hs = 1'b0; clear_err = 1'b0;
    cnt_load = 1'b0; load_frame = '0; load_drop = '0;

    // Reset values
    do_reset();
    check("rst_start", seq_ap_start, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_state", dbg_state, S_IDLE);

    // Nominal frame
    enable = 1'b1; seq_ap_ready = 1'b1; nn_ap_ready = 1'b1;
    sof_pulse();
    check("nom_arm_state", dbg_state, S_ARM);
    check("nom_arm_start", seq_ap_start, 1);
    check("nom_arm_busy", busy, 1);
    tick();
    check("nom_run_state", dbg_state, S_RUN);
    check("nom_run_start", seq_ap_start, 0);
    pixels(31);
    check("nom_31px_run", dbg_state, S_RUN);
    pixels(1);
    check("nom_32px_drain", dbg_state, S_DRAIN);
    repeat (3) tick();
    check("nom_drain_wait", dbg_state, S_DRAIN);
    finish_frame();
    check("nom_idle_state", dbg_state, S_IDLE);
    check("nom_idle_busy", busy, 0);
    tick();

    // Back-pressure: nn_ap_ready low for 10 cycles in ARM
    nn_ap_ready = 1'b0;
    sof_pulse();
    start_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      if (seq_ap_start === 1'b1) start_cycles++;
      tick();
    end
    check("bp_start_cycles", start_cycles, 10);
    check("bp_still_arm", dbg_state, S_ARM);
    nn_ap_ready = 1'b1;
    check("bp_accept_start", seq_ap_start, 1);
    tick();
    check("bp_run_state", dbg_state, S_RUN);
    check("bp_run_start", seq_ap_start, 0);
    pixels(32);
    check("bp_drain", dbg_state, S_DRAIN);
    finish_frame();
    tick();

    // Drops: one sof with enable low, three during RUN, enable dropped mid-frame
    do_reset();
    enable = 1'b0;
    sof_pulse();
    check("drop_disabled_idle", dbg_state, S_IDLE);
    check("drop_disabled_cnt", drop_cnt, 1);
    enable = 1'b1; seq_ap_ready = 1'b0;
    sof_pulse();
    repeat (3) tick();
    check("drop_seq_not_ready_arm", dbg_state, S_ARM);
    seq_ap_ready = 1'b1;
    tick();
    check("drop_run_state", dbg_state, S_RUN);
    pixels(10);
    sof_pulse();
    pixels(10);
    enable = 1'b0;
    sof_pulse();
    pixels(5);
    sof_pulse();
    pixels(7);
    check("drop_drain", dbg_state, S_DRAIN);
    check("drop_cnt_4", drop_cnt, 4);
    finish_frame();
    check("drop_cnt_after", drop_cnt, 4);
    enable = 1'b1;
    tick();

    // Timeout into ERR, then clear
    do_reset();
    sof_pulse(); tick();
    pixels(10);
    repeat (15) tick();
    check("to_15_idle_run", dbg_state, S_RUN);
    check("to_15_terr", timeout_err, 0);
    tick();
    check("to_16_err", dbg_state, S_ERR);
    check("to_terr", timeout_err, 1);
    check("to_busy", busy, 1);
    pixels(3);
    check("to_pix_in_err", dbg_state, S_ERR);
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    check("to_clear_idle", dbg_state, S_IDLE);
    check("to_clear_terr", timeout_err, 0);
    check("to_frame_cnt", frame_cnt, 0);

    // Handshake on the 16th stalled cycle avoids ERR
    sof_pulse(); tick();
    pixels(10);
    repeat (15) tick();
    pixels(1);
    check("av_saved_run", dbg_state, S_RUN);
    repeat (15) tick();
    check("av_wd_restart", dbg_state, S_RUN);
    pixels(21);
    check("av_drain", dbg_state, S_DRAIN);
    finish_frame();
    tick();

    // Reset in the middle of RUN
    do_reset();
    sof_pulse(); tick();
    pixels(32);
    finish_frame();
    tick();
    sof_pulse(); tick();
    pixels(20);
    sof_pulse();
    check("mr_pre_drop", drop_cnt, 1);
    check("mr_pre_frame", frame_cnt, 1);
    reset = 1'b1; sof = 1'b1; pix_hs = 1'b1; clear_err = 1'b1;
    tick();
    reset = 1'b0; sof = 1'b0; pix_hs = 1'b0; clear_err = 1'b0;
    exp_frames = '0;
    check("mr_state", dbg_state, S_IDLE);
    check("mr_start", seq_ap_start, 0);
    check("mr_busy", busy, 0);
    check("mr_done", frame_done, 0);
    check("mr_terr", timeout_err, 0);
    check("mr_frame", frame_cnt, 0);
    check("mr_drop", drop_cnt, 0);
    sof_pulse(); tick();
    pixels(31);
    check("mr_31px_run", dbg_state, S_RUN);
    pixels(1);
    check("mr_32px_drain", dbg_state, S_DRAIN);
    finish_frame();
    tick();

    // Wrap of frame_cnt and saturation of drop_cnt
    do_reset();
    cnt_load = 1'b1; load_frame = 16'hFFFF; load_drop = 16'hFFFF;
    tick();
    cnt_load = 1'b0;
    check("ws_load_frame", frame_cnt, 16'hFFFF);
    check("ws_load_drop", drop_cnt, 16'hFFFF);
    exp_frames = 16'hFFFF;
    sof_pulse(); tick();
    pixels(16);
    sof_pulse();
    check("ws_drop_sat", drop_cnt, 16'hFFFF);
    pixels(16);
    finish_frame();
    tick();
    check("ws_frame_wrap", frame_cnt, 0);
    check("ws_drop_final", drop_cnt, 16'hFFFF);

    repeat (3) tick();
    check("sb_empty_at_end", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
